// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the cache-to-RAM path
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_D = 2'b01,
    SERVE_I = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a single-port RAM
// Data wins ties; a saturating starvation count forces a pending fetch through.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             d_req;
  logic             access;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == ACCESS);

  always_comb begin
    state_d  = state_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (iREN && (!d_req || starve_q == STARVE_LIM)) state_d = SERVE_I;
        else if (d_req)                                  state_d = SERVE_D;
      end
      SERVE_D: begin
        ramaddr = daddr;
        // A request withdrawn mid-service releases the RAM without completing.
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (access) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_d = IDLE;
          end
        end
      end
      SERVE_I: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (access) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!iREN)
      starve_d = '0;
    else if (state_q == SERVE_I && access)
      starve_d = '0;
    else if (state_q == SERVE_D && d_req && access && starve_q != STARVE_LIM)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter
// Reference model tracks the RAM owner, starvation count and memory contents.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          owner    = 0;  // 0 none, 1 data, 2 instruction
  int          starve   = 0;
  int          i_cnt    = 0;
  int          d_cnt    = 0;
  bit          i_done, d_done;
  logic [31:0] mem [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    logic        er, ew, iw, dw, dreq, acc;
    logic [31:0] ea, es, il, dl;
    int          nxt;
    dreq = dREN | dWEN;
    acc  = (ramstate == 2'b10);
    case (owner)
      1:       ramload = mem[daddr[9:2]];
      2:       ramload = mem[iaddr[9:2]];
      default: ramload = $urandom;
    endcase
    #1;
    er = 0; ew = 0; ea = 0; es = 0; iw = 1; dw = 1; il = 0; dl = 0;
    if (owner == 1) begin
      ea = daddr;
      if (dreq) begin
        if (dWEN) begin ew = 1; es = dstore; end
        else er = 1;
        if (acc) begin dw = 0; dl = dWEN ? 32'h0 : mem[daddr[9:2]]; end
      end
    end else if (owner == 2) begin
      ea = iaddr;
      if (iREN) begin
        er = 1;
        if (acc) begin iw = 0; il = mem[iaddr[9:2]]; end
      end
    end
    check("ramREN", ramREN, er);
    check("ramWEN", ramWEN, ew);
    check("ramaddr", ramaddr, ea);
    check("ramstore", ramstore, es);
    check("iwait", iwait, iw);
    check("dwait", dwait, dw);
    check("iload", iload, il);
    check("dload", dload, dl);
    check("wait_excl", iwait | dwait, 1);
    i_done = !iw;
    d_done = !dw;
    if (d_done) begin
      d_cnt++;
      if (dWEN) mem[daddr[9:2]] = dstore;
    end
    if (i_done) i_cnt++;
    nxt = owner;
    if (owner == 0) begin
      if (iREN && (!dreq || starve == 4)) nxt = 2;
      else if (dreq) nxt = 1;
    end else if (owner == 1) begin
      if (!dreq || d_done) nxt = 0;
    end else begin
      if (!iREN || i_done) nxt = 0;
    end
    if (!iREN) starve = 0;
    else if (i_done) starve = 0;
    else if (d_done && starve < 4) starve++;
    owner = nxt;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    owner  = 0;
    starve = 0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
  endtask

  initial begin
    int first_done, seen, dc;
    nRST = 0; idle_inputs();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'b00;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    @(negedge CLK);
    do_reset();

    // Single instruction read with two BUSY cycles
    mem[8'h10] = 32'hDEADBEEF;
    iREN = 1; iaddr = 32'h40; ramstate = 2'b01;
    step();
    step(); step();
    ramstate = 2'b10;
    dc = i_cnt;
    step();
    check("ifetch_done", i_cnt - dc, 1);
    idle_inputs(); step();

    // Write wins over read when both are raised
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h12345678; ramstate = 2'b10;
    step(); step();
    check("wr_done", d_done, 1);
    idle_inputs(); step();

    // Simultaneous requests: data first
    iREN = 1; iaddr = 32'h8; dREN = 1; daddr = 32'h200; ramstate = 2'b10;
    first_done = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (first_done == 0 && d_done) first_done = 1;
      if (first_done == 0 && i_done) first_done = 2;
      if (d_done) dREN = 0;
      if (i_done) begin iREN = 0; break; end
    end
    check("prio_first", first_done, 1);
    idle_inputs(); step();

    // Starvation bound: two rounds of exactly four data completions per fetch
    for (int r = 0; r < 2; r++) begin
      iREN = 1; iaddr = 32'h4; dREN = 1; daddr = 32'h300; ramstate = 2'b10;
      dc = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        step();
        if (d_done) dc++;
        if (i_done) seen = 1;
      end
      check("starve_grant", seen, 1);
      check("starve_dcount", dc, 4);
    end
    idle_inputs(); step();

    // ERROR is retried until ACCESS
    iREN = 1; iaddr = 32'h80; ramstate = 2'b11;
    dc = i_cnt;
    step(); step(); step(); step();
    check("err_no_done", i_cnt - dc, 0);
    ramstate = 2'b10;
    step();
    check("err_done", i_cnt - dc, 1);
    idle_inputs(); step();

    // Request dropped while being served
    dREN = 1; daddr = 32'h44; ramstate = 2'b01;
    step(); step();
    dREN = 0;
    step(); step();

    // Reset while a data access is in flight
    dREN = 1; daddr = 32'h120; ramstate = 2'b01;
    step(); step();
    ramstate = 2'b10;
    do_reset();
    idle_inputs(); step();

    // Randomized protocol-respecting traffic
    for (int k = 0; k < 3000; k++) begin
      if (i_done || !iREN) begin
        iREN  = 1'($urandom_range(0, 1));
        iaddr = 32'($urandom_range(0, 255)) << 2;
      end
      if (d_done || !(dREN | dWEN)) begin
        {dWEN, dREN} = 2'($urandom_range(0, 3));
        daddr  = 32'($urandom_range(0, 255)) << 2;
        dstore = $urandom;
      end
      ramstate = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 2)) ^ 2'b00;
      if (ramstate == 2'b10 && $urandom_range(0, 1) == 0) ramstate = 2'b11;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
